data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 28 ++
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-lane synchronous write, registered read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wbe,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory slave for the CPU MEM stage: accepts one load/store at a
// time, stalls the pipeline via busy, and answers with a single-cycle response pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] writeData,
  input  logic [3:0]        byteEn,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] readData,
  output logic              readValid,
  output logic              writeDone,
  output logic              busy,
  output logic              error
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, next_cnt;
  logic [AW-1:0]     cap_idx;
  logic [DATA_W-1:0] cap_data;
  logic [3:0]        cap_be;
  logic              cap_write;

  logic              req_any, req_bad, accept, reject, access_done, mem_we;
  logic [AW-1:0]     req_idx, rd_idx;
  logic [DATA_W-1:0] arr_rdata;

  assign req_idx = address[AW+1:2];

  always_comb begin
    req_any     = memRead | memWrite;
    req_bad     = (memRead & memWrite) || (address[1:0] != 2'b00) || (address >= LIMIT);
    accept      = (state == IDLE) && req_any && !req_bad;
    reject      = (state == IDLE) && req_any && req_bad;
    access_done = (state == ACCESS) && (cnt == '0);
    next_state  = state;
    next_cnt    = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = ACCESS;
          next_cnt   = CNT_INIT;
        end
      end
      ACCESS: begin
        if (cnt == '0) next_state = RESP;
        else           next_cnt   = cnt - CNT_W'(1);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Gating with rst keeps an aborted store from landing on the reset edge.
    mem_we = access_done && cap_write && !rst;
    // In IDLE the array is pre-read from the live address so the word is ready
    // by the end of ACCESS even when LATENCY is 1.
    rd_idx = (state == IDLE) ? req_idx : cap_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      readData <= '0;
      error    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      error <= reject;
      if (access_done && !cap_write) readData <= arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      cap_idx   <= req_idx;
      cap_data  <= writeData;
      cap_be    <= byteEn;
      cap_write <= memWrite;
    end
  end

  assign busy      = (state != IDLE);
  assign readValid = (state == RESP) && !cap_write;
  assign writeDone = (state == RESP) && cap_write;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cap_idx),
    .wdata (cap_data),
    .wbe   (cap_be),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default-parameter instance plus a LATENCY=1 instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, writeData;
  logic [3:0]  byteEn;
  logic        memRead, memWrite;
  logic [31:0] readData;
  logic        readValid, writeDone, busy, error;

  logic [31:0] address1, writeData1;
  logic [3:0]  byteEn1;
  logic        memRead1, memWrite1;
  logic [31:0] readData1;
  logic        readValid1, writeDone1, busy1, error1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .writeData (writeData),
    .byteEn    (byteEn),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .readData  (readData),
    .readValid (readValid),
    .writeDone (writeDone),
    .busy      (busy),
    .error     (error)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .address   (address1),
    .writeData (writeData1),
    .byteEn    (byteEn1),
    .memRead   (memRead1),
    .memWrite  (memWrite1),
    .readData  (readData1),
    .readValid (readValid1),
    .writeDone (writeDone1),
    .busy      (busy1),
    .error     (error1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Strobe held for exactly one edge; returns at the negedge after that edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    memRead   = rd;
    memWrite  = wr;
    address   = addr;
    writeData = data;
    byteEn    = be;
    @(negedge clk);
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic doRequest(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    int cyc;
    int busyCyc;
    applyStimulus(!wr, wr, addr, data, be);
    cyc     = 1;
    busyCyc = 0;
    while (!(readValid || writeDone) && cyc < 20) begin
      busyCyc += int'(busy);
      @(negedge clk);
      cyc++;
    end
    busyCyc += int'(busy);
    checkOutput({tag, "_latency"}, cyc, 3);
    checkOutput({tag, "_busycycles"}, busyCyc, 3);
    checkOutput({tag, "_pulse"}, {30'd0, writeDone, readValid}, wr ? 32'd2 : 32'd1);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {28'd0, busy, readValid, writeDone, error}, 32'd0);
  endtask

  task automatic doReject(input string tag, input logic rd, input logic wr, input logic [31:0] addr);
    applyStimulus(rd, wr, addr, 32'h0BAD_0BAD, 4'hF);
    checkOutput({tag, "_errpulse"}, {28'd0, error, busy, readValid, writeDone}, 32'h8);
    @(negedge clk);
    checkOutput({tag, "_errclear"}, {30'd0, error, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    logic [11:0] rvPat, busyPat, rvExp, busyExp;
    int errSeen;

    rst        = 1'b1;
    memRead    = 1'b1;
    memWrite   = 1'b0;
    address    = 32'h0;
    writeData  = 32'h0;
    byteEn     = 4'h0;
    memRead1   = 1'b0;
    memWrite1  = 1'b0;
    address1   = 32'h0;
    writeData1 = 32'h0;
    byteEn1    = 4'h0;

    // A load strobe held through reset must not start a request.
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {28'd0, busy, readValid, writeDone, error}, 32'd0);
    checkOutput("reset_readData", readData, 32'h0);
    checkOutput("reset_dut1_busy", {31'd0, busy1}, 32'd0);
    rst     = 1'b0;
    memRead = 1'b0;

    doRequest("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    doRequest("ld10", 1'b0, 32'h10, 32'h0, 4'b0000);
    checkOutput("ld10_data", readData, 32'hDEADBEEF);

    doRequest("st10_lane1", 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    doRequest("ld10_b", 1'b0, 32'h10, 32'h0, 4'b0000);
    checkOutput("ld10_lane1_data", readData, 32'hDEADAAEF);

    doRequest("st10_nolanes", 1'b1, 32'h10, 32'h00000000, 4'b0000);
    doRequest("ld10_c", 1'b0, 32'h10, 32'h0, 4'b0000);
    checkOutput("ld10_nolanes_data", readData, 32'hDEADAAEF);

    doRequest("st3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111);
    doRequest("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'b0000);
    checkOutput("ld3fc_data", readData, 32'hCAFEF00D);

    doReject("misaligned", 1'b1, 1'b0, 32'h12);
    doReject("outofrange", 1'b1, 1'b0, 32'h400);
    doReject("bothstrobes", 1'b1, 1'b1, 32'h10);
    checkOutput("reject_holds_readData", readData, 32'hCAFEF00D);

    // Reset in the first ACCESS cycle of a store must drop it entirely.
    doRequest("st20", 1'b1, 32'h20, 32'h12345678, 4'b1111);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b1111);
    checkOutput("abort_in_access", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_readData_cleared", readData, 32'h0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(writeDone) + int'(readValid) + int'(error);
    end
    checkOutput("abort_no_pulse", pulses, 0);
    doRequest("ld20", 1'b0, 32'h20, 32'h0, 4'b0000);
    checkOutput("ld20_data", readData, 32'h12345678);

    // LATENCY=1 instance with memRead held: one accept every 3 cycles.
    @(negedge clk);
    memRead1 = 1'b1;
    errSeen  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rvPat[i]   = readValid1;
      busyPat[i] = busy1;
      rvExp[i]   = ((i + 1) % 3 == 2);
      busyExp[i] = ((i + 1) % 3 != 0);
      errSeen   += int'(error1) + int'(writeDone1);
    end
    memRead1 = 1'b0;
    checkOutput("lat1_readValid_pattern", {20'd0, rvPat}, {20'd0, rvExp});
    checkOutput("lat1_busy_pattern", {20'd0, busyPat}, {20'd0, busyExp});
    checkOutput("lat1_no_other_pulses", errSeen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
